// File: rtl/picosoc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// picosoc_mem_arbiter : two-master round-robin arbiter with watchdog for the
//                       PicoSoC native memory bus.            Rev 1.0
// ============================================================================
module picosoc_mem_arbiter #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        timeout_err
);

   localparam bit                WDOG_EN   = (TIMEOUT_CYCLES > 0);
   localparam int                WDOG_W    = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_EN ? WDOG_W'(TIMEOUT_CYCLES - 1) : '0;

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10
   } state_t;

   state_t            r_state;
   logic              r_last_grant;
   logic [WDOG_W-1:0] r_wdog;

   logic        w_busy;
   logic        w_sel1;
   logic        w_mvalid;
   logic        w_timeout;
   logic        w_done;
   logic [31:0] w_rdata;

   // Reset also masks the bus so an abandoned transfer never completes.
   assign w_busy    = (r_state != ST_IDLE) && !reset;
   assign w_sel1    = (r_state == ST_GRANT1);
   assign w_mvalid  = w_sel1 ? m1_valid : m0_valid;
   assign w_timeout = WDOG_EN && w_busy && w_mvalid && !s_ready && (r_wdog == WDOG_LAST);
   assign w_done    = w_busy && w_mvalid && (s_ready || w_timeout);
   assign w_rdata   = s_ready ? s_rdata : ERR_RDATA;

   assign s_valid     = w_busy && w_mvalid && !w_timeout;
   assign s_instr     = w_busy && (w_sel1 ? m1_instr : m0_instr);
   assign s_addr      = w_busy ? (w_sel1 ? m1_addr  : m0_addr)  : '0;
   assign s_wdata     = w_busy ? (w_sel1 ? m1_wdata : m0_wdata) : '0;
   assign s_wstrb     = w_busy ? (w_sel1 ? m1_wstrb : m0_wstrb) : '0;

   assign m0_ready    = w_done && !w_sel1;
   assign m1_ready    = w_done &&  w_sel1;
   assign m0_rdata    = m0_ready ? w_rdata : '0;
   assign m1_rdata    = m1_ready ? w_rdata : '0;
   assign timeout_err = w_timeout;
   assign grant       = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_wdog       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_wdog <= '0;
               if (m0_valid && (!m1_valid || r_last_grant))
                  r_state <= ST_GRANT0;
               else if (m1_valid)
                  r_state <= ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
               // Completion, watchdog expiry and master abort all release the bus.
               if (!w_mvalid || w_done) begin
                  r_state      <= ST_IDLE;
                  r_last_grant <= w_sel1;
                  r_wdog       <= '0;
               end else if (WDOG_EN) begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_picosoc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_picosoc_mem_arbiter : scoreboard bench for the two-master bus arbiter.
// ============================================================================
module tb_picosoc_mem_arbiter;

   localparam int          TMO = 8;
   localparam logic [31:0] ERR = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        s_ready;
   logic [31:0] s_rdata;

   logic        m0_ready, m1_ready, s_valid, s_instr, timeout_err;
   logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;

   logic        d4_m0_ready, d4_m1_ready, d4_s_valid, d4_s_instr, d4_timeout_err;
   logic [31:0] d4_m0_rdata, d4_m1_rdata, d4_s_addr, d4_s_wdata;
   logic [3:0]  d4_s_wstrb;
   logic [1:0]  d4_grant;

   typedef struct {
      logic [1:0]  who;
      logic [31:0] rdata;
      logic        tmo;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;
   bit   mon_en   = 1'b0;

   always #5 clk = ~clk;

   picosoc_mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .timeout_err(timeout_err)
   );

   // Short-watchdog instance sharing the same stimulus, used for the threshold race.
   picosoc_mem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(ERR)) dut4 (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(d4_m0_ready), .m0_rdata(d4_m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(d4_m1_ready), .m1_rdata(d4_m1_rdata),
      .s_valid(d4_s_valid), .s_instr(d4_s_instr), .s_addr(d4_s_addr), .s_wdata(d4_s_wdata),
      .s_wstrb(d4_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(d4_grant), .timeout_err(d4_timeout_err)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Completion monitor: every ready pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (mon_en) begin
         if (m0_ready || m1_ready) begin
            if (sb.size() == 0) begin
               check_val("unexpected_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check_val("ready_who", {30'd0, m1_ready, m0_ready}, {30'd0, mon_e.who});
               check_val("ready_rdata", m0_ready ? m0_rdata : m1_rdata, mon_e.rdata);
               check_val("other_rdata", m0_ready ? m1_rdata : m0_rdata, 32'd0);
               check_val("timeout_err", {31'd0, timeout_err}, {31'd0, mon_e.tmo});
            end
         end else begin
            check_val("rdata_idle", m0_rdata | m1_rdata, 32'd0);
            check_val("tmo_idle", {31'd0, timeout_err}, 32'd0);
         end
      end
   end

   task automatic push_exp(input logic [1:0] who, input logic [31:0] rd, input logic tmo);
      exp_t e;
      e.who   = who;
      e.rdata = rd;
      e.tmo   = tmo;
      sb.push_back(e);
   endtask

   task automatic wait_grant(input logic [1:0] g);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (grant == g) break;
      end
      check_val("grant_on", {30'd0, grant}, {30'd0, g});
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Single-master transfer; slave answers on grant cycle lat (0 = never).
   task automatic xfer(input bit m, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input int lat, input logic [31:0] rd, input bit chk4);
      logic [1:0] g;
      bit         tmo;
      bit         last;
      bit         tcyc;
      g   = m ? 2'b10 : 2'b01;
      tmo = (lat == 0) || (lat > TMO);
      @(posedge clk); #1;
      if (m) begin
         m1_valid = 1'b1; m1_instr = instr; m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb;
      end else begin
         m0_valid = 1'b1; m0_instr = instr; m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb;
      end
      push_exp(g, tmo ? ERR : rd, tmo);
      wait_grant(g);
      for (int n = 1; n <= TMO; n++) begin
         tcyc    = tmo && (n == TMO);
         last    = (n == lat) || tcyc;
         s_ready = (n == lat);
         s_rdata = (n == lat) ? rd : 32'h5A5A_5A5A;
         @(negedge clk);
         check_val("s_valid", {31'd0, s_valid}, {31'd0, !tcyc});
         check_val("s_addr", s_addr, addr);
         check_val("s_wdata", s_wdata, wdata);
         check_val("s_wstrb", {28'd0, s_wstrb}, {28'd0, strb});
         check_val("s_instr", {31'd0, s_instr}, {31'd0, instr});
         if (chk4 && n == lat) begin
            check_val("thr_ready", {31'd0, d4_m0_ready}, 32'd1);
            check_val("thr_rdata", d4_m0_rdata, rd);
            check_val("thr_tmo", {31'd0, d4_timeout_err}, 32'd0);
         end
         @(posedge clk); #1;
         s_ready = 1'b0;
         if (last) break;
      end
      if (m) m1_valid = 1'b0; else m0_valid = 1'b0;
      @(negedge clk);
      check_val("grant_idle", {30'd0, grant}, 32'd0);
      check_val("s_valid_idle", {31'd0, s_valid}, 32'd0);
      check_val("s_addr_idle", s_addr, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout: got stuck expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [1:0]  g;
      logic [31:0] a;
      reset    = 1'b1;
      m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_ready  = 1'b0; s_rdata  = '0;
      repeat (3) @(posedge clk);
      #1 mon_en = 1'b1;

      @(negedge clk);
      check_val("rst_grant", {30'd0, grant}, 32'd0);
      check_val("rst_s_valid", {31'd0, s_valid}, 32'd0);
      check_val("rst_s_addr", s_addr, 32'd0);
      check_val("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
      check_val("rst_tmo", {31'd0, timeout_err}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // m0 instruction read; slave answers on the 4th grant cycle (watchdog-4 threshold).
      xfer(1'b0, 1'b1, 32'h0000_0010, 32'h0, 4'h0, 4, 32'hDEAD_BEEF, 1'b1);

      // Simultaneous requests from reset: m0 first, then strict alternation.
      pulse_reset();
      m0_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wstrb = 4'h0;
      m1_valid = 1'b1; m1_addr = 32'h0000_2000; m1_wstrb = 4'h0;
      for (int k = 0; k < 4; k++) push_exp((k % 2 == 0) ? 2'b01 : 2'b10, 32'h1000_0000 + k, 1'b0);
      for (int k = 0; k < 4; k++) begin
         g = (k % 2 == 0) ? 2'b01 : 2'b10;
         a = (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
         @(posedge clk); #1;
         s_ready = 1'b1;
         s_rdata = 32'h1000_0000 + k;
         @(negedge clk);
         check_val("alt_grant", {30'd0, grant}, {30'd0, g});
         check_val("alt_addr", s_addr, a);
         @(posedge clk); #1;
         s_ready = 1'b0;
         if (k == 3) begin
            m0_valid = 1'b0;
            m1_valid = 1'b0;
         end
         @(negedge clk);
         check_val("alt_idle", {30'd0, grant}, 32'd0);
      end

      // m1 byte write.
      xfer(1'b1, 1'b0, 32'h0200_0004, 32'h0000_00A5, 4'b0001, 2, 32'h0, 1'b0);

      // Slave never answers: watchdog ends it on grant cycle 8; bus still usable after.
      xfer(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 32'h0, 1'b0);
      xfer(1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0);

      // Reset during GRANT1 with the slave answering: transfer is dropped.
      @(posedge clk); #1;
      m1_valid = 1'b1; m1_addr = 32'h0000_3000; m1_wstrb = 4'h0;
      wait_grant(2'b10);
      reset   = 1'b1;
      s_ready = 1'b1;
      s_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      s_ready = 1'b0;
      @(negedge clk);
      check_val("rstmid_s_valid", {31'd0, s_valid}, 32'd0);
      check_val("rstmid_grant", {30'd0, grant}, 32'd0);
      @(posedge clk); #1;
      reset    = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h0000_4000;
      push_exp(2'b01, 32'hAAAA_0001, 1'b0);
      push_exp(2'b10, 32'hAAAA_0002, 1'b0);
      @(posedge clk); #1;
      s_ready = 1'b1; s_rdata = 32'hAAAA_0001;
      @(negedge clk);
      check_val("tie_after_rst", {30'd0, grant}, 32'd1);
      @(posedge clk); #1;
      s_ready  = 1'b0;
      m0_valid = 1'b0;
      @(posedge clk); #1;
      s_ready = 1'b1; s_rdata = 32'hAAAA_0002;
      @(negedge clk);
      check_val("m1_after_m0", {30'd0, grant}, 32'd2);
      @(posedge clk); #1;
      s_ready  = 1'b0;
      m1_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("sb_drained", sb.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
